fpdiv_ctrl: RTL and testbench

Sequencer for the Goldschmidt floating-point divider datapath. It accepts a start request and drives the datapath controls cycle by cycle: the A/B operand mux selects and the A/B/C/R register enables. These controls run the initial-approximation, iteration and remainder phases. It signals completion so the rounding, exponent and sign logic can sample the result. The block is instantiated beside the fpdiv datapath in the divider top level.

---
 rtl/fpdiv_pkg.sv | 24 ++
 rtl/fpdiv_iter_cnt.sv | 37 +++
 rtl/fpdiv_ctrl.sv | 121 ++++++++++++
 tb/tb_fpdiv_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and mux-select encodings for the Goldschmidt divider
// sequencer and its datapath.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT_D = 3'd1,
        S_INIT_X = 3'd2,
        S_ITER_N = 3'd3,
        S_ITER_D = 3'd4,
        S_REM    = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam logic [1:0] MUXA_REGA = 2'b00;
    localparam logic [1:0] MUXA_D    = 2'b01;
    localparam logic [1:0] MUXA_IA   = 2'b10;

    localparam logic [1:0] MUXB_D    = 2'b00;
    localparam logic [1:0] MUXB_X    = 2'b01;
    localparam logic [1:0] MUXB_REGB = 2'b10;
    localparam logic [1:0] MUXB_REGC = 2'b11;

endpackage

// File: rtl/fpdiv_iter_cnt.sv
// Refinement counter: clear has priority over increment; tc_o flags the
// last N step so the sequencer can skip the trailing D update.
module fpdiv_iter_cnt #(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, matching the hardware.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: Moore FSM stepping the datapath through
// initial approximation, ITERS N/D refinements and the remainder product.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       enA,
    output logic       enB,
    output logic       enC,
    output logic       enR,
    output logic       busy,
    output logic       done
);

    state_e state_q, state_d;
    logic   cnt_clr, cnt_inc, last_n;

    fpdiv_iter_cnt #(
        .ITERS (ITERS),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clock (clock),
        .reset (reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (last_n)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_INIT_D;
                    cnt_clr = 1'b1;
                end
            end
            S_INIT_D: state_d = S_INIT_X;
            S_INIT_X: state_d = S_ITER_N;
            S_ITER_N: begin
                cnt_inc = 1'b1;
                state_d = last_n ? S_REM : S_ITER_D;
            end
            S_ITER_D: state_d = S_ITER_N;
            S_REM:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort drops straight back to IDLE; datapath registers keep whatever
        // they last captured.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        sel_muxa = MUXA_REGA;
        sel_muxb = MUXB_D;
        enA      = 1'b0;
        enB      = 1'b0;
        enC      = 1'b0;
        enR      = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        unique case (state_q)
            S_INIT_D: begin
                sel_muxa = MUXA_IA;
                sel_muxb = MUXB_D;
                enA      = 1'b1;
                enC      = 1'b1;
            end
            S_INIT_X: begin
                sel_muxa = MUXA_IA;
                sel_muxb = MUXB_X;
                enB      = 1'b1;
            end
            S_ITER_N: begin
                sel_muxa = MUXA_REGA;
                sel_muxb = MUXB_REGB;
                enB      = 1'b1;
            end
            S_ITER_D: begin
                sel_muxa = MUXA_REGA;
                sel_muxb = MUXB_REGC;
                enA      = 1'b1;
                enC      = 1'b1;
            end
            S_REM: begin
                sel_muxa = MUXA_D;
                sel_muxb = MUXB_REGB;
                enR      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: an ITERS=3 instance for most scenarios and
// an ITERS=1 instance for the short sequence.
module tb_fpdiv_ctrl;

    logic       clock;
    logic       reset;
    logic       start3, abort3, start1, abort1;
    logic [1:0] muxa3, muxb3, muxa1, muxb1;
    logic       enA3, enB3, enC3, enR3, busy3, done3;
    logic       enA1, enB1, enC1, enR1, busy1, done1;
    logic [9:0] obs3, obs1;

    int checks   = 0;
    int failures = 0;

    fpdiv_ctrl #(.ITERS(3), .CNT_W(3)) dut3 (
        .clock    (clock),
        .reset    (reset),
        .start    (start3),
        .abort    (abort3),
        .sel_muxa (muxa3),
        .sel_muxb (muxb3),
        .enA      (enA3),
        .enB      (enB3),
        .enC      (enC3),
        .enR      (enR3),
        .busy     (busy3),
        .done     (done3)
    );

    fpdiv_ctrl #(.ITERS(1), .CNT_W(1)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .start    (start1),
        .abort    (abort1),
        .sel_muxa (muxa1),
        .sel_muxb (muxb1),
        .enA      (enA1),
        .enB      (enB1),
        .enC      (enC1),
        .enR      (enR1),
        .busy     (busy1),
        .done     (done1)
    );

    // Observed vector layout: {sel_muxa, sel_muxb, enA, enB, enC, enR, busy, done}
    assign obs3 = {muxa3, muxb3, enA3, enB3, enC3, enR3, busy3, done3};
    assign obs1 = {muxa1, muxb1, enA1, enB1, enC1, enR1, busy1, done1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected vector for cycle k after the start-sampling edge, ITERS=3.
    function automatic logic [9:0] exp3(input int k);
        case (k)
            1:       return 10'b10_00_1010_1_0;
            2:       return 10'b10_01_0100_1_0;
            3:       return 10'b00_10_0100_1_0;
            4:       return 10'b00_11_1010_1_0;
            5:       return 10'b00_10_0100_1_0;
            6:       return 10'b00_11_1010_1_0;
            7:       return 10'b00_10_0100_1_0;
            8:       return 10'b01_10_0001_1_0;
            9:       return 10'b00_00_0000_1_1;
            default: return 10'b00_00_0000_0_0;
        endcase
    endfunction

    function automatic logic [9:0] exp1(input int k);
        case (k)
            1:       return 10'b10_00_1010_1_0;
            2:       return 10'b10_01_0100_1_0;
            3:       return 10'b00_10_0100_1_0;
            4:       return 10'b01_10_0001_1_0;
            5:       return 10'b00_00_0000_1_1;
            default: return 10'b00_00_0000_0_0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (obs3 !== 10'b0 || obs1 !== 10'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: got %b/%b expected all zero", i, obs3, obs1);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (obs3 !== 10'b0 || obs1 !== 10'b0) begin
                failures++;
                $display("FAIL idle cyc%0d: got %b/%b expected all zero", i, obs3, obs1);
            end
        end
    endtask

    task automatic test_iters3(input string tag);
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (obs3 !== exp3(k)) begin
                failures++;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, k, obs3, exp3(k));
            end
        end
    endtask

    task automatic test_iters1();
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (obs1 !== exp1(k)) begin
                failures++;
                $display("FAIL iters1 cycle %0d: got %b expected %b", k, obs1, exp1(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        start3 = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (obs3 !== exp3(((k - 1) % 10) + 1)) begin
                failures++;
                $display("FAIL b2b cycle %0d: got %b expected %b",
                         k, obs3, exp3(((k - 1) % 10) + 1));
            end
            if (k == 19) start3 = 1'b0;
        end
    endtask

    task automatic test_abort();
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (obs3 !== exp3(k)) begin
                failures++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", k, obs3, exp3(k));
            end
        end
        abort3 = 1'b1;
        @(negedge clock);
        abort3 = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            if (k > 5) @(negedge clock);
            checks++;
            if (obs3 !== 10'b0) begin
                failures++;
                $display("FAIL abort_post cycle %0d: got %b expected %b", k, obs3, 10'b0);
            end
        end
        test_iters3("after_abort");
    endtask

    task automatic test_reset_rem();
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (obs3 !== exp3(k)) begin
                failures++;
                $display("FAIL rst_pre cycle %0d: got %b expected %b", k, obs3, exp3(k));
            end
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (obs3 !== 10'b0) begin
            failures++;
            $display("FAIL rst_in_rem: got %b expected %b", obs3, 10'b0);
        end
        start3 = 1'b1;
        abort3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (obs3 !== 10'b0) begin
                failures++;
                $display("FAIL start_abort_idle cyc%0d: got %b expected %b", i, obs3, 10'b0);
            end
        end
        start3 = 1'b0;
        abort3 = 1'b0;
        test_iters3("after_reset");
    endtask

    initial begin
        reset  = 1'b1;
        start3 = 1'b0;
        abort3 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        test_reset();
        test_iters3("iters3");
        test_iters1();
        test_back_to_back();
        test_abort();
        test_reset_rem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
